seg_scan4: RTL

Four-digit multiplexed 7-segment display driver, downstream of the BCD counter stages. It latches four BCD digits plus decimal points and time-multiplexes them onto one shared active-low segment bus. It drives active-low digit anodes and inserts an all-off gap between digits to suppress ghosting. Displayed data updates only at frame boundaries, so a multi-digit value never tears mid-scan.

---
 rtl/seg_scan4.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/seg_scan4.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan4
// Purpose  : Four-digit multiplexed 7-segment driver with per-slot blanking gap
//            and frame-aligned display update. Optional leading-zero blanking
//            when LZ_BLANK_EN is defined.
// Revision : 1.0
// ============================================================================
module seg_scan4 #(
  parameter int unsigned REFRESH_DIV = 3000,
  parameter int unsigned GAP_CYC     = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] bcd,
  input  logic [3:0]  dp,
  input  logic        load,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int unsigned        c_cnt_w   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REFRESH_DIV - 1);

  localparam logic [0:0] c_st_gap  = 1'b0;
  localparam logic [0:0] c_st_show = 1'b1;
  localparam logic [0:0] c_st_rst  = (GAP_CYC == 0) ? c_st_show : c_st_gap;

  logic [c_cnt_w-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]         idx_q, idx_d;
  logic [19:0]        pending_q, pending_d;
  logic [19:0]        disp_q, disp_d;
  logic [0:0]         state_q, state_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_n_q, dp_n_d;
  logic [3:0]         an_q, an_d;
  logic               frame_q, frame_d;

  logic               w_wrap;
  logic               w_frame;
  logic               w_in_gap;
  logic               w_blank;
  logic [3:0]         w_digit;
  logic [3:0]         w_dp_vec;
  logic               w_dp;

  function automatic logic [6:0] f_decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Outputs are registered from next-state values so they line up with div_cnt.
  always_comb begin
    w_wrap    = (div_cnt_q == c_cnt_max);
    w_frame   = w_wrap && (idx_q == 2'd3);
    div_cnt_d = w_wrap ? '0 : div_cnt_q + 1'b1;
    idx_d     = w_wrap ? idx_q + 2'd1 : idx_q;
    pending_d = load ? {dp, bcd} : pending_q;
    disp_d    = w_frame ? pending_d : disp_q;
    frame_d   = (div_cnt_d == c_cnt_max) && (idx_d == 2'd3);
  end

  generate
    if (GAP_CYC == 0) begin : g_no_gap
      assign w_in_gap = 1'b0;
    end else begin : g_gap
      localparam logic [c_cnt_w-1:0] c_gap = c_cnt_w'(GAP_CYC);
      assign w_in_gap = (div_cnt_d < c_gap);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= c_st_rst;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = w_in_gap ? c_st_gap : c_st_show;
  end

  assign w_digit  = disp_d[{idx_d, 2'b00} +: 4];
  assign w_dp_vec = disp_d[19:16];
  assign w_dp     = w_dp_vec[idx_d];

`ifdef LZ_BLANK_EN
  always_comb begin
    w_blank = 1'b0;
    case (idx_d)
      2'd3:    w_blank = (disp_d[15:12] == 4'd0);
      2'd2:    w_blank = (disp_d[15:8] == 8'd0);
      2'd1:    w_blank = (disp_d[15:4] == 12'd0);
      default: w_blank = 1'b0;
    endcase
  end
`else
  assign w_blank = 1'b0;
`endif

  always_comb begin
    an_d   = 4'b1111;
    seg_d  = 7'b1111111;
    dp_n_d = 1'b1;
    if (state_d == c_st_show) begin
      an_d   = ~(4'b0001 << idx_d);
      seg_d  = w_blank ? 7'b1111111 : f_decode(w_digit);
      dp_n_d = ~w_dp;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
      idx_q     <= 2'd0;
      pending_q <= 20'd0;
      disp_q    <= 20'd0;
      seg_q     <= 7'b1111111;
      dp_n_q    <= 1'b1;
      an_q      <= 4'b1111;
      frame_q   <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      disp_q    <= disp_d;
      seg_q     <= seg_d;
      dp_n_q    <= dp_n_d;
      an_q      <= an_d;
      frame_q   <= frame_d;
    end
  end

  assign seg        = seg_q;
  assign dp_n       = dp_n_q;
  assign an         = an_q;
  assign frame_tick = frame_q;

endmodule
`default_nettype wire
